// File: rtl/jedro_1_data_arbiter_pkg.sv
// Shared definitions for the jedro_1 data-RAM arbiter: lock states,
// master indices and byte-enable width helpers.
package jedro_1_defines;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        LOCKED_M0 = 2'd1,
        LOCKED_M1 = 2'd2
    } lock_state_e;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int BE_WIDTH       = DATA_WIDTH_DEF / 8;

    localparam int M0 = 0;
    localparam int M1 = 1;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/jedro_1_data_arbiter_if.sv
// One master's request/response bundle towards the data-RAM arbiter.
// The master modport belongs to the requester, slave to the arbiter.
interface jedro_1_data_arbiter_if
    import jedro_1_defines::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    localparam int BW = be_width(DATA_WIDTH);

    logic                  req;
    logic [BW-1:0]         we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  lock;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/jedro_1_data_arbiter_rr_arbiter.sv
// Two-input round-robin grant generator. On a conflict the input that was
// not granted most recently wins; rr_last resets to 1 so input 0 wins first.
module jedro_1_rr_arbiter
    import jedro_1_defines::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_last;

    // No grant may be issued while reset is held, even though grants are combinational.
    always_comb begin
        gnt = 2'b00;
        if (rstn) begin
            if (req[M0] && (!req[M1] || rr_last)) begin
                gnt[M0] = 1'b1;
            end else if (req[M1]) begin
                gnt[M1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_last <= 1'b1;
        end else if (gnt[M0]) begin
            rr_last <= 1'b0;
        end else if (gnt[M1]) begin
            rr_last <= 1'b1;
        end
    end

endmodule

// File: rtl/jedro_1_data_arbiter.sv
// Shares the jedro_1 data RAM between the core LSU (m0) and a secondary master (m1).
// Define JEDRO_1_ARB_LOCK_EN to enable bus locking for read-modify-write sequences.
module jedro_1_data_arbiter
    import jedro_1_defines::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)(
    input  logic                    clk_i,
    input  logic                    rstn_i,
    jedro_1_data_arbiter_if.slave   m0,
    jedro_1_data_arbiter_if.slave   m1,
    output logic                    ram_en_o,
    output logic [DATA_WIDTH/8-1:0] ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    logic [1:0] req_eff;
    logic [1:0] gnt;
    logic       resp_pending;
    logic       resp_owner;

`ifdef JEDRO_1_ARB_LOCK_EN
    lock_state_e lock_state;
    lock_state_e lock_next;

    // While one master holds the lock the other one's request is hidden from arbitration.
    always_comb begin
        req_eff     = 2'b00;
        req_eff[M0] = m0.req && (lock_state != LOCKED_M1);
        req_eff[M1] = m1.req && (lock_state != LOCKED_M0);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            lock_state <= UNLOCKED;
        end else begin
            lock_state <= lock_next;
        end
    end

    always_comb begin
        lock_next = lock_state;
        case (lock_state)
            UNLOCKED: begin
                if (gnt[M0] && m0.lock) begin
                    lock_next = LOCKED_M0;
                end else if (gnt[M1] && m1.lock) begin
                    lock_next = LOCKED_M1;
                end
            end
            LOCKED_M0: begin
                if (gnt[M0] && !m0.lock) begin
                    lock_next = UNLOCKED;
                end
            end
            LOCKED_M1: begin
                if (gnt[M1] && !m1.lock) begin
                    lock_next = UNLOCKED;
                end
            end
            default: lock_next = UNLOCKED;
        endcase
    end
`else
    logic unused_lock;

    assign unused_lock = m0.lock ^ m1.lock;

    always_comb begin
        req_eff     = 2'b00;
        req_eff[M0] = m0.req;
        req_eff[M1] = m1.req;
    end
`endif

    jedro_1_rr_arbiter u_rr_arbiter (
        .clk  (clk_i),
        .rstn (rstn_i),
        .req  (req_eff),
        .gnt  (gnt)
    );

    assign m0.gnt = gnt[M0];
    assign m1.gnt = gnt[M1];

    // The winner's command goes straight to the RAM; idle cycles drive all zeros.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (gnt[M0]) begin
            ram_en_o    = 1'b1;
            ram_we_o    = m0.we;
            ram_addr_o  = m0.addr;
            ram_wdata_o = m0.wdata;
        end else if (gnt[M1]) begin
            ram_en_o    = 1'b1;
            ram_we_o    = m1.we;
            ram_addr_o  = m1.addr;
            ram_wdata_o = m1.wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            resp_pending <= 1'b0;
            resp_owner   <= 1'b0;
        end else begin
            resp_pending <= ram_en_o && (ram_we_o == '0);
            if (ram_en_o) begin
                resp_owner <= gnt[M1];
            end
        end
    end

    // Gating with rstn_i drops a response whose cycle coincides with reset.
    always_comb begin
        m0.rvalid = rstn_i && resp_pending && !resp_owner;
        m1.rvalid = rstn_i && resp_pending &&  resp_owner;
        m0.rdata  = m0.rvalid ? ram_rdata_i : '0;
        m1.rdata  = m1.rvalid ? ram_rdata_i : '0;
    end

endmodule

// File: tb/tb_jedro_1_data_arbiter.sv
// Self-checking bench for jedro_1_data_arbiter: a transaction-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_jedro_1_data_arbiter;
    import jedro_1_defines::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    jedro_1_data_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
    jedro_1_data_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();

    jedro_1_data_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    always #5 clk = ~clk;

    // Bytewrite RAM with one-cycle read latency standing in for the real wrapper.
    logic [31:0] ram_mem [64] = '{default: 32'h0};

    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram_mem[ram_addr[7:2]];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(
        input logic r0, input logic [3:0] we0, input logic [31:0] a0, input logic [31:0] d0, input logic l0,
        input logic r1, input logic [3:0] we1, input logic [31:0] a1, input logic [31:0] d1, input logic l1);
        m0_bus.req = r0; m0_bus.we = we0; m0_bus.addr = a0; m0_bus.wdata = d0; m0_bus.lock = l0;
        m1_bus.req = r1; m1_bus.we = we1; m1_bus.addr = a1; m1_bus.wdata = d1; m1_bus.lock = l1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: who should win, what the RAM sees, and which read comes back.
    int          m_last = 1;
    int          m_lock = -1;
    bit          m_pend = 1'b0;
    int          m_owner = 0;
    logic [31:0] m_data = 32'h0;
    logic [31:0] gold [64] = '{default: 32'h0};

    always @(negedge clk) begin : compare
        int          win;
        logic [3:0]  w_we;
        logic [31:0] w_addr, w_wdata;
        logic        w_lock;
        logic        e_gnt0, e_gnt1, e_en, e_rv0, e_rv1;
        logic [3:0]  e_we;
        logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;

        win = -1;
        w_we = 4'h0; w_addr = 32'h0; w_wdata = 32'h0; w_lock = 1'b0;
        e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_en = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
        e_we = 4'h0; e_addr = 32'h0; e_wdata = 32'h0; e_rd0 = 32'h0; e_rd1 = 32'h0;

        if (rstn) begin
            if (m0_bus.req && m_lock != 1 && m1_bus.req && m_lock != 0) win = (m_last == 0) ? 1 : 0;
            else if (m0_bus.req && m_lock != 1) win = 0;
            else if (m1_bus.req && m_lock != 0) win = 1;

            if (win == 0) begin
                w_we = m0_bus.we; w_addr = m0_bus.addr; w_wdata = m0_bus.wdata; w_lock = m0_bus.lock;
            end else if (win == 1) begin
                w_we = m1_bus.we; w_addr = m1_bus.addr; w_wdata = m1_bus.wdata; w_lock = m1_bus.lock;
            end
            e_gnt0 = (win == 0);
            e_gnt1 = (win == 1);
            e_en   = (win >= 0);
            e_we = w_we; e_addr = w_addr; e_wdata = w_wdata;
            if (m_pend && m_owner == 0) begin e_rv0 = 1'b1; e_rd0 = m_data; end
            if (m_pend && m_owner == 1) begin e_rv1 = 1'b1; e_rd1 = m_data; end
        end

        checkOutput("gnt0", m0_bus.gnt, e_gnt0);
        checkOutput("gnt1", m1_bus.gnt, e_gnt1);
        checkOutput("ram_en", ram_en, e_en);
        checkOutput("ram_we", ram_we, e_we);
        checkOutput("ram_addr", ram_addr, e_addr);
        checkOutput("ram_wdata", ram_wdata, e_wdata);
        checkOutput("rvalid0", m0_bus.rvalid, e_rv0);
        checkOutput("rvalid1", m1_bus.rvalid, e_rv1);
        checkOutput("rdata0", m0_bus.rdata, e_rd0);
        checkOutput("rdata1", m1_bus.rdata, e_rd1);

        if (!rstn) begin
            m_last = 1;
            m_lock = -1;
            m_pend = 1'b0;
        end else begin
            m_pend = 1'b0;
            if (win >= 0) begin
                m_last = win;
                if (w_we == 4'h0) begin
                    m_pend  = 1'b1;
                    m_owner = win;
                    m_data  = gold[w_addr[7:2]];
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_we[b]) gold[w_addr[7:2]][8*b +: 8] = w_wdata[8*b +: 8];
                    end
                end
`ifdef JEDRO_1_ARB_LOCK_EN
                if (m_lock == -1 && w_lock) m_lock = win;
                else if (m_lock == win && !w_lock) m_lock = -1;
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held with both masters requesting full-word writes
        rstn = 1'b0;
        applyStimulus(1, 4'hF, 32'h0, 32'hA0A0A0A0, 0, 1, 4'hF, 32'h4, 32'hB1B1B1B1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_gnt0", m0_bus.gnt, 1'b0);
            checkOutput("rst_gnt1", m1_bus.gnt, 1'b0);
            checkOutput("rst_ram_en", ram_en, 1'b0);
            nextCycle();
        end
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("first_gnt0", m0_bus.gnt, 1'b1);
        checkOutput("first_gnt1", m1_bus.gnt, 1'b0);
        nextCycle();
        applyStimulus(0, 4'h0, 32'h0, 32'h0, 0, 1, 4'hF, 32'h4, 32'hB1B1B1B1, 0);
        @(negedge clk);
        checkOutput("stalled_m1_gnt", m1_bus.gnt, 1'b1);
        nextCycle();

        // Contention: continuous reads from both masters
        applyStimulus(1, 4'h0, 32'h0, 32'h0, 0, 1, 4'h0, 32'h4, 32'h0, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("alt_gnt0", m0_bus.gnt, (k % 2) == 0);
            if (k > 0) begin
                checkOutput("alt_rvalid0", m0_bus.rvalid, ((k - 1) % 2) == 0);
                checkOutput("alt_rdata", m0_bus.rdata | m1_bus.rdata,
                            (((k - 1) % 2) == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
            end
            nextCycle();
        end
        applyStimulus(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        checkOutput("alt_last_rvalid1", m1_bus.rvalid, 1'b1);
        checkOutput("alt_last_rdata1", m1_bus.rdata, 32'hB1B1B1B1);
        nextCycle();

        // Uncontended write then read by m1
        applyStimulus(0, 4'h0, 32'h0, 32'h0, 0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0);
        @(negedge clk);
        checkOutput("unc_wr_gnt1", m1_bus.gnt, 1'b1);
        nextCycle();
        applyStimulus(0, 4'h0, 32'h0, 32'h0, 0, 1, 4'h0, 32'h10, 32'h0, 0);
        @(negedge clk);
        checkOutput("unc_rd_gnt1", m1_bus.gnt, 1'b1);
        checkOutput("unc_wr_no_rvalid", m1_bus.rvalid, 1'b0);
        nextCycle();
        applyStimulus(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        checkOutput("unc_rvalid1", m1_bus.rvalid, 1'b1);
        checkOutput("unc_rdata1", m1_bus.rdata, 32'hDEADBEEF);
        checkOutput("unc_rvalid0", m0_bus.rvalid, 1'b0);
        nextCycle();

        // Byte write over a preloaded word
        applyStimulus(1, 4'hF, 32'h20, 32'h11223344, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        nextCycle();
        applyStimulus(1, 4'b0001, 32'h20, 32'h000000AA, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        nextCycle();
        applyStimulus(1, 4'h0, 32'h20, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        nextCycle();
        applyStimulus(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        checkOutput("byte_rdata0", m0_bus.rdata, 32'h112233AA);
        nextCycle();

        // Lock sequence: m1 locked read then unlocking write, m0 requesting throughout
        applyStimulus(1, 4'h0, 32'h0, 32'h0, 0, 1, 4'h0, 32'h10, 32'h0, 1);
        @(negedge clk);
        checkOutput("lock_l0_gnt1", m1_bus.gnt, 1'b1);
        nextCycle();
        applyStimulus(1, 4'h0, 32'h0, 32'h0, 0, 1, 4'hF, 32'h14, 32'h00000055, 0);
`ifdef JEDRO_1_ARB_LOCK_EN
        @(negedge clk);
        checkOutput("lock_l1_gnt0", m0_bus.gnt, 1'b0);
        checkOutput("lock_l1_gnt1", m1_bus.gnt, 1'b1);
        nextCycle();
`else
        @(negedge clk);
        checkOutput("nolock_l1_gnt0", m0_bus.gnt, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("nolock_l2_gnt1", m1_bus.gnt, 1'b1);
        nextCycle();
`endif
        applyStimulus(1, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        checkOutput("lock_after_gnt0", m0_bus.gnt, 1'b1);
        nextCycle();

        // Reset in the cycle after a granted read
        applyStimulus(1, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        nextCycle();
        rstn = 1'b0;
        applyStimulus(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        checkOutput("midrst_rvalid0", m0_bus.rvalid, 1'b0);
        nextCycle();
        rstn = 1'b1;
        applyStimulus(1, 4'h0, 32'h0, 32'h0, 0, 1, 4'h0, 32'h4, 32'h0, 0);
        @(negedge clk);
        checkOutput("postrst_rvalid0", m0_bus.rvalid, 1'b0);
        checkOutput("postrst_gnt0", m0_bus.gnt, 1'b1);
        nextCycle();
        applyStimulus(0, 4'h0, 32'h0, 32'h0, 0, 1, 4'h0, 32'h4, 32'h0, 0);
        nextCycle();
        applyStimulus(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        nextCycle();
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/jedro_1_data_arbiter.md
# jedro_1_data_arbiter

Two-master, single-slave arbiter that shares the jedro_1 data RAM (bytewrite RAM, one-cycle read latency) between the core's load/store port (master 0) and a secondary master such as a debug/loader or DMA engine (master 1). It sits between those masters and the RAM wrapper. It performs round-robin arbitration per cycle, routes read data back to the master that issued the read, and optionally supports bus locking for read-modify-write sequences.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8

Ports (x = 0, 1):
- clk_i  in  1  clock; all logic on rising edge
- rstn_i  in  1  reset, synchronous, active-low
- mx_req_i  in  1  master x requests an access this cycle
- mx_we_i  in  DATA_WIDTH/8  byte write enables; all-zero means read
- mx_addr_i  in  ADDR_WIDTH  byte address
- mx_wdata_i  in  DATA_WIDTH  write data
- mx_lock_i  in  1  hold ownership after this access (only with lock feature)
- mx_gnt_o  out  1  access accepted this cycle (combinational from req and state)
- mx_rvalid_o  out  1  read data valid, one cycle after a granted read
- mx_rdata_o  out  DATA_WIDTH  read data, valid with mx_rvalid_o
- ram_en_o  out  1  RAM command strobe
- ram_we_o  out  DATA_WIDTH/8  RAM byte write enables
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_rdata_i  in  DATA_WIDTH  RAM read data, one cycle after ram_en_o

## Operation
- At most one grant per cycle. The granted master's command drives ram_* in the same cycle, and ram_en_o = 1.
- Arbitration:
  - If only one master requests, it wins.
  - If both request, the master not granted most recently wins. The rr_last register updates on every grant; its reset value is 1, so master 0 wins the first conflict.
- A non-granted master keeps its req and command stable until granted. The arbiter does not latch commands.
- For a granted read (we == 0), resp_owner and resp_pending are registered. Next cycle, mx_rvalid_o = 1 for the owner only, and mx_rdata_o = ram_rdata_i.
- rdata is routed only to the owner. The other master's rdata_o is 0.
- Writes produce no rvalid.
- Back-to-back reads from alternating masters are legal. The rvalid for read N and the grant for read N+1 occur in the same cycle.
- Idle cycles: ram_en_o = 0, ram_we_o = 0, and address/wdata are 0.
- Reset values: all gnt, rvalid, and ram_en are 0; all data/address outputs are 0; rr_last = 1; resp_pending = 0; lock state UNLOCKED.
- Reset asserted mid-read drops the pending response. No rvalid is issued after reset.

## Timing
- Grant latency is 0 cycles when uncontended, and at most 1 cycle of waiting under contention with the lock feature off.
- Read latency: rvalid exactly 1 cycle after gnt.
- Throughput: one access per cycle in aggregate.
- Lock FSM (feature enabled): states UNLOCKED, LOCKED_M0, LOCKED_M1.
  - UNLOCKED -> LOCKED_Mx when master x is granted with mx_lock_i = 1.
  - In LOCKED_Mx only master x can be granted; the other master's requests stall.
  - LOCKED_Mx -> UNLOCKED when master x is granted with mx_lock_i = 0.
  - A locked master that stops requesting keeps ownership indefinitely.

## Configuration
- JEDRO_1_ARB_LOCK_EN defined: the lock ports are functional and the lock FSM is present.
- JEDRO_1_ARB_LOCK_EN undefined: the lock ports are ignored, the FSM is removed, and arbitration is pure round-robin.

## Structure
- The shared package jedro_1_defines holds:
  - the lock_state_e enum (UNLOCKED, LOCKED_M0, LOCKED_M1);
  - the localparam for byte-enable width;
  - the master-index constants M0 = 0, M1 = 1.
- One sub-module, jedro_1_rr_arbiter: a 2-input round-robin grant generator with an rr_last register, reusable for future fetch/data sharing. Response routing and the lock FSM stay in the top.

## Test plan
- Reset: hold rstn_i = 0 for 3 cycles with both req = 1 -> all gnt, rvalid, and ram_en are 0; first cycle after release grants m0.
- Uncontended: m1 writes 0xDEADBEEF to 0x10 with we = 4'hF, then reads 0x10 -> gnt same cycle as req; m1_rvalid_o exactly one cycle after the read grant with rdata 0xDEADBEEF; m0_rvalid_o stays 0.
- Contention: both masters read continuously at 0x0/0x4 for 6 cycles -> grants alternate m0, m1, m0, ...; each rvalid goes to the correct owner with the correct word.
- Byte write: m0 writes 0x000000AA to 0x20 with we = 4'b0001 over a preloaded 0x11223344 -> a readback returns 0x112233AA.
- Lock (JEDRO_1_ARB_LOCK_EN): m1 reads with lock = 1, then writes with lock = 0 while m0 requests throughout -> m0 gets no grant until the cycle after m1's unlocking write; without the macro, grants alternate.
- Reset mid-read: drop rstn_i in the cycle after a granted read -> no rvalid is observed, and state returns to its reset values.
